idct4_stream: RTL and testbench

IDCT4_STREAM -- requirements
Module: idct4_stream

---
 rtl/idct4_stream.sv | 204 ++++++++++++++++++++
 tb/tb_idct4_stream.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct4_stream.sv
// -----------------------------------------------------------------------------
// idct4_stream
//
// Streaming 4-point inverse DCT (HEVC-style integer basis 64/83/36).
// Accepts four signed coefficients X0..X3 over a valid/ready port, computes
// one reconstructed sample per cycle into a small output buffer, then emits
// x0..x3 over a second valid/ready port.  Only one block is in flight at a
// time: input is closed while a block is computed or sent.
//
// Parameters
//   IN_W   coefficient width (signed)
//   OUT_W  sample width (signed)
//   SHIFT  normalisation right-shift applied after rounding
//
// Ports
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    coefficient beat valid
//   in_ready    block accepts a coefficient beat (high only while loading)
//   in_coef     signed coefficient, order X0, X1, X2, X3
//   out_valid   sample beat valid (high only while sending)
//   out_ready   downstream accepts a sample beat
//   out_sample  signed reconstructed sample, order x0, x1, x2, x3
//   out_last    high with the x3 beat only
//   out_sat     high when the presented sample was clipped
// -----------------------------------------------------------------------------
module idct4_stream #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8,
    parameter int SHIFT = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_coef,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_sample,
    output logic                    out_last,
    output logic                    out_sat
);

    // Largest |sum| is 247 * 2^(IN_W-1), which fits in IN_W+8 signed bits.
    localparam int ACC_W = IN_W + 8;

    localparam logic signed [ACC_W-1:0] C64  = ACC_W'(64);
    localparam logic signed [ACC_W-1:0] C83  = ACC_W'(83);
    localparam logic signed [ACC_W-1:0] C36  = ACC_W'(36);
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_e;

    state_e                   state_q;
    logic [1:0]               idx_q;
    logic signed [IN_W-1:0]   coef_q [4];
    logic signed [OUT_W-1:0]  buf_q  [4];
    logic [3:0]               sat_q;

    logic                     in_ready_q;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_sample_q;
    logic                     out_last_q;
    logic                     out_sat_q;

    // Combinational datapath for the sample selected by idx_q
    logic [1:0]               idx_d;
    logic signed [ACC_W-1:0]  xe     [4];
    logic signed [ACC_W-1:0]  even_p;
    logic signed [ACC_W-1:0]  even_m;
    logic signed [ACC_W-1:0]  odd_a;
    logic signed [ACC_W-1:0]  odd_b;
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  biased_d;
    logic signed [ACC_W-1:0]  shr_d;
    logic signed [OUT_W-1:0]  smp_d;
    logic                     sat_d;

    assign idx_d = idx_q + 2'd1;

    // Butterfly form of the 4x4 basis:
    //   x0 = E+ + O_a    x1 = E- + O_b    x2 = E- - O_b    x3 = E+ - O_a
    // with E+/- = 64*X0 +/- 64*X2, O_a = 83*X1 + 36*X3, O_b = 36*X1 - 83*X3.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            xe[i] = {{(ACC_W - IN_W){coef_q[i][IN_W-1]}}, coef_q[i]};
        end
        even_p = (C64 * xe[0]) + (C64 * xe[2]);
        even_m = (C64 * xe[0]) - (C64 * xe[2]);
        odd_a  = (C83 * xe[1]) + (C36 * xe[3]);
        odd_b  = (C36 * xe[1]) - (C83 * xe[3]);

        sum_d = '0;
        case (idx_q)
            2'd0:    sum_d = even_p + odd_a;
            2'd1:    sum_d = even_m + odd_b;
            2'd2:    sum_d = even_m - odd_b;
            2'd3:    sum_d = even_p - odd_a;
            default: sum_d = '0;
        endcase

        // Round half up, then floor via arithmetic shift
        biased_d = sum_d + RND;
        shr_d    = biased_d >>> SHIFT;

        smp_d = shr_d[OUT_W-1:0];
        sat_d = 1'b0;
        if (shr_d > SMAX) begin
            smp_d = SMAX[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (shr_d < SMIN) begin
            smp_d = SMIN[OUT_W-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            idx_q        <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                coef_q[i] <= '0;
                buf_q[i]  <= '0;
            end
            sat_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            out_last_q   <= 1'b0;
            out_sat_q    <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid alone
                    // marks an accepted beat; idle cycles just hold idx_q.
                    if (in_valid) begin
                        coef_q[idx_q] <= in_coef;
                        idx_q         <= idx_d;
                        if (idx_q == 2'd3) begin
                            state_q    <= CALC;
                            in_ready_q <= 1'b0;
                        end
                    end
                end

                CALC: begin
                    buf_q[idx_q] <= smp_d;
                    sat_q[idx_q] <= sat_d;
                    idx_q        <= idx_d;
                    if (idx_q == 2'd3) begin
                        // x0 was written three cycles earlier, so it can be
                        // presented in the same edge that enters SEND.
                        state_q      <= SEND;
                        out_valid_q  <= 1'b1;
                        out_sample_q <= buf_q[0];
                        out_sat_q    <= sat_q[0];
                        out_last_q   <= 1'b0;
                    end
                end

                SEND: begin
                    if (out_ready) begin
                        idx_q <= idx_d;
                        if (idx_q == 2'd3) begin
                            state_q      <= LOAD;
                            in_ready_q   <= 1'b1;
                            out_valid_q  <= 1'b0;
                            out_sample_q <= '0;
                            out_sat_q    <= 1'b0;
                            out_last_q   <= 1'b0;
                        end else begin
                            out_sample_q <= buf_q[idx_d];
                            out_sat_q    <= sat_q[idx_d];
                            out_last_q   <= (idx_q == 2'd2);
                        end
                    end
                end

                default: begin
                    state_q      <= LOAD;
                    idx_q        <= '0;
                    in_ready_q   <= 1'b1;
                    out_valid_q  <= 1'b0;
                    out_sample_q <= '0;
                    out_sat_q    <= 1'b0;
                    out_last_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign out_last   = out_last_q;
    assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_idct4_stream.sv
// -----------------------------------------------------------------------------
// tb_idct4_stream
//
// Directed bench for idct4_stream.  Stimulus tasks push hand-computed
// expected samples into a queue; an independent monitor pops and compares on
// every output transfer, and also watches handshake/stability rules.
// -----------------------------------------------------------------------------
module tb_idct4_stream;

    localparam int IN_W  = 10;
    localparam int OUT_W = 8;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_coef   = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [OUT_W-1:0] out_sample;
    logic                    out_last;
    logic                    out_sat;

    idct4_stream #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coef    (in_coef),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_last   (out_last),
        .out_sat    (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [OUT_W-1:0] smp;
        logic                    sat;
        logic                    lst;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_in_cyc = 0;
    int xfer_cnt    = 0;
    int rdy_mode    = 0;
    int rdy_k       = 0;
    bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n && out_valid && out_ready) xfer_cnt++;
    end

    // Sole driver of out_ready after time 0: held high, or a 1,0,0,1 pattern
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            out_ready = rdy_pat[rdy_k];
            rdy_k     = (rdy_k + 1) % 4;
        end else begin
            out_ready = 1'b1;
            rdy_k     = 0;
        end
    end

    // ---------------------------------------------------------------- monitor
    logic prev_valid  = 1'b0;
    logic expect_idle = 1'b0;
    logic held_v      = 1'b0;
    exp_t held;
    exp_t e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (expect_idle) begin
                check("in_ready_after_x3", int'(in_ready), 1);
                expect_idle = 1'b0;
            end
            if (out_valid) begin
                if (!prev_valid) check("latency", cyc - last_in_cyc, 4);
                check("in_ready_low_in_send", int'(in_ready), 0);
                if (held_v) begin
                    check("stall_sample", int'(out_sample), int'($signed(held.smp)));
                    check("stall_sat", int'(out_sat), int'(held.sat));
                    check("stall_last", int'(out_last), int'(held.lst));
                end
                if (out_ready) begin
                    held_v = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_output", int'(out_sample), 9999);
                    end else begin
                        e = sb.pop_front();
                        check("sample", int'(out_sample), int'($signed(e.smp)));
                        check("sat", int'(out_sat), int'(e.sat));
                        check("last", int'(out_last), int'(e.lst));
                        if (e.lst) expect_idle = 1'b1;
                    end
                end else begin
                    held   = '{smp: out_sample, sat: out_sat, lst: out_last};
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
                check("idle_outputs", int'({out_sample, out_last, out_sat}), 0);
            end
            prev_valid = out_valid;
        end else begin
            prev_valid  = 1'b0;
            held_v      = 1'b0;
            expect_idle = 1'b0;
        end
    end

    // ---------------------------------------------------------------- drivers
    // Every driver step starts just after a rising edge.
    task automatic put_beat(input int v, input int gap);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_coef  = IN_W'(v);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_coef  = 10'sh155;
    endtask

    task automatic send_block(input int xs[4], input int es[4], input bit ss[4],
                              input int gap, input bit pulse);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{smp: OUT_W'(es[i]), sat: ss[i], lst: (i == 3)});
        end
        for (int i = 0; i < 4; i++) begin
            put_beat(xs[i], gap);
        end
        last_in_cyc = cyc;
        if (pulse) begin
            // Spurious beats while the block is computing must be ignored
            in_valid = 1'b1;
            in_coef  = 10'sh1AA;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sample", int'(out_sample), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- main
    initial begin : main
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_sample", int'(out_sample), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_out_sat", int'(out_sat), 0);
        rst_n = 1'b1;

        // DC, accepted starting on the first edge after release
        send_block('{128, 0, 0, 0}, '{64, 64, 64, 64}, '{0, 0, 0, 0}, 0, 0);
        wait_drain();

        // AC1
        send_block('{0, 100, 0, 0}, '{65, 28, -28, -65}, '{0, 0, 0, 0}, 0, 0);
        wait_drain();

        // Positive full-scale: x3 = (9*511+64)>>7 = 36 is the only unclipped one
        send_block('{511, 511, 511, 511}, '{127, -128, 127, 36}, '{1, 1, 1, 0}, 0, 0);
        wait_drain();

        // Negative DC full-scale: (-32768+64)>>7 = -256 clips to -128
        send_block('{-512, 0, 0, 0}, '{-128, -128, -128, -128}, '{1, 1, 1, 1}, 0, 0);
        wait_drain();

        // Backpressure on AC1
        rdy_mode = 1;
        send_block('{0, 100, 0, 0}, '{65, 28, -28, -65}, '{0, 0, 0, 0}, 0, 0);
        wait_drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset right after x1 of an AC1 block transfers
        base = xfer_cnt;
        send_block('{0, 100, 0, 0}, '{65, 28, -28, -65}, '{0, 0, 0, 0}, 0, 0);
        n = 0;
        while (xfer_cnt < base + 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("xfer_before_reset", xfer_cnt - base, 2);
        reset_pulse();
        sb.delete();
        send_block('{128, 0, 0, 0}, '{64, 64, 64, 64}, '{0, 0, 0, 0}, 0, 0);
        wait_drain();

        // Reset after two beats of a block have loaded
        put_beat(0, 0);
        put_beat(100, 0);
        reset_pulse();
        send_block('{128, 0, 0, 0}, '{64, 64, 64, 64}, '{0, 0, 0, 0}, 0, 0);
        wait_drain();

        // Idle gaps between beats plus ignored beats during computation
        send_block('{128, 0, 0, 0}, '{64, 64, 64, 64}, '{0, 0, 0, 0}, 2, 1);
        wait_drain();
        send_block('{0, 100, 0, 0}, '{65, 28, -28, -65}, '{0, 0, 0, 0}, 0, 0);
        wait_drain();

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
